// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory access master.
//  - Default widths: AW (address), DW (data), LW (burst length field).
//  - state_t: sequencer states.
//      IDLE    : waiting for a request
//      WR      : single-beat write in flight
//      RD_WAIT : read strobe being sampled by the memory
//      RD_CAP  : capture read data
//      RESP    : read beat presented to the client
package mem_if_pkg;
   localparam int AW_DEF = 5;
   localparam int DW_DEF = 8;
   localparam int LW_DEF = 5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_WAIT = 3'd2,
      RD_CAP  = 3'd3,
      RESP    = 3'd4
   } state_t;
endpackage

// File: rtl/mem_access_master_if.sv
// Client-side request/response channel of the memory access master.
//  request : req_valid/req_ready handshake with req_write, req_adr, req_wdata, req_len
//  response: rsp_valid/rsp_ready handshake with rsp_data, rsp_last
// Modports:
//  master : the requesting client (drives req_*, rsp_ready)
//  slave  : the memory access master (drives req_ready, rsp_*)
interface mem_access_master_if
   import mem_if_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF,
   parameter int LW = LW_DEF
) ();
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_adr;
   logic [DW-1:0] req_wdata;
   logic [LW-1:0] req_len;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_last;

   modport master (
      output req_valid, req_write, req_adr, req_wdata, req_len, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_last
   );

   modport slave (
      input  req_valid, req_write, req_adr, req_wdata, req_len, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_last
   );
endinterface

// File: rtl/mem_access_master.sv
// Memory access master: initiator side of a single-port synchronous memory.
// Accepts single-beat writes and incrementing read bursts from a client and
// sequences memwen/memRead to the memory; read data goes back to the client
// over a valid/ready response channel. This is the only block driving the
// memory strobes.
// Ports:
//  clk    : clock, all state updates on posedge
//  rst_n  : asynchronous active-low reset
//  client : request/response channel (slave modport)
//  busy   : high whenever the sequencer is not IDLE
//  adr    : memory address (registered, wraps modulo 2**AW)
//  data   : memory write data (registered)
//  memwen : memory write strobe, one cycle per write
//  memRead: memory read strobe, one cycle per beat
//  resMem : memory read data, valid the cycle after memRead is sampled
module mem_access_master
   import mem_if_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF,
   parameter int LW = LW_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_access_master_if.slave   client,
   output logic                 busy,
   output logic [AW-1:0]        adr,
   output logic [DW-1:0]        data,
   output logic                 memwen,
   output logic                 memRead,
   input  logic [DW-1:0]        resMem
);

   state_t        state_reg;
   state_t        state_next;
   logic [LW-1:0] cnt_reg;
   logic          req_ready_reg;
   logic          rsp_valid_reg;
   logic          rsp_last_reg;
   logic [DW-1:0] rsp_data_reg;
   logic [AW-1:0] adr_reg;
   logic [DW-1:0] data_reg;
   logic          memwen_reg;
   logic          mem_read_reg;
   logic          accept;

   // req_ready is only ever high in IDLE, so this is the accept condition.
   assign accept = req_ready_reg & client.req_valid;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = client.req_write ? WR : RD_WAIT;
         WR:      state_next = IDLE;
         RD_WAIT: state_next = RD_CAP;
         RD_CAP:  state_next = RESP;
         RESP: begin
            if (client.rsp_ready) state_next = (cnt_reg == '0) ? IDLE : RD_WAIT;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         req_ready_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_last_reg  <= 1'b0;
         rsp_data_reg  <= '0;
         adr_reg       <= '0;
         data_reg      <= '0;
         memwen_reg    <= 1'b0;
         mem_read_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               // req_ready is low only on the first edge after reset; raise it
               // there so nothing is accepted before that edge.
               if (!req_ready_reg) begin
                  req_ready_reg <= 1'b1;
               end else if (client.req_valid) begin
                  req_ready_reg <= 1'b0;
                  adr_reg       <= client.req_adr;
                  if (client.req_write) begin
                     data_reg   <= client.req_wdata;
                     memwen_reg <= 1'b1;
                  end else begin
                     mem_read_reg <= 1'b1;
                     cnt_reg      <= client.req_len;
                  end
               end
            end
            WR: begin
               memwen_reg    <= 1'b0;
               req_ready_reg <= 1'b1;
            end
            RD_WAIT: begin
               mem_read_reg <= 1'b0;
            end
            RD_CAP: begin
               rsp_data_reg  <= resMem;
               rsp_valid_reg <= 1'b1;
               rsp_last_reg  <= (cnt_reg == '0);
            end
            RESP: begin
               // Under backpressure everything holds: no address step, no strobe.
               if (client.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  rsp_last_reg  <= 1'b0;
                  if (cnt_reg != '0) begin
                     adr_reg      <= adr_reg + 1'b1;   // natural wrap at 2**AW
                     cnt_reg      <= cnt_reg - 1'b1;
                     mem_read_reg <= 1'b1;
                  end else begin
                     req_ready_reg <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy             = (state_reg != IDLE);
   assign adr              = adr_reg;
   assign data             = data_reg;
   assign memwen           = memwen_reg;
   assign memRead          = mem_read_reg;
   assign client.req_ready = req_ready_reg;
   assign client.rsp_valid = rsp_valid_reg;
   assign client.rsp_data  = rsp_data_reg;
   assign client.rsp_last  = rsp_last_reg;

endmodule

// File: tb/tb_mem_access_master.sv
// Directed testbench for mem_access_master with a registered-read memory model.
module tb_mem_access_master;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy;
   logic [4:0] adr;
   logic [7:0] data;
   logic       memwen;
   logic       mem_read;
   logic [7:0] res_mem;

   always #5 clk = ~clk;

   mem_access_master_if #(.AW(5), .DW(8), .LW(5)) client ();

   mem_access_master #(.AW(5), .DW(8), .LW(5)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .client  (client),
      .busy    (busy),
      .adr     (adr),
      .data    (data),
      .memwen  (memwen),
      .memRead (mem_read),
      .resMem  (res_mem)
   );

   // Memory model: preloaded while in reset, write on memwen, registered read.
   logic [7:0] mem [0:31];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
         mem[0]  <= 8'h9D;
         mem[1]  <= 8'h9D;
         mem[27] <= 8'h66;
         mem[28] <= 8'hAA;
         mem[29] <= 8'h08;
         mem[30] <= 8'h10;
         mem[31] <= 8'h00;
      end else begin
         if (memwen) mem[adr] <= data;
         if (mem_read) res_mem <= mem[adr];
      end
   end

   // Strobe monitor
   int         rd_cnt = 0;
   int         wr_cnt = 0;
   int         both_err = 0;
   logic [4:0] rd_adr_q[$];
   always @(posedge clk) begin
      if (rst_n) begin
         if (mem_read) begin
            rd_cnt++;
            rd_adr_q.push_back(adr);
         end
         if (memwen) wr_cnt++;
         if (mem_read && memwen) both_err++;
      end
   end

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   logic [7:0] beat_data [0:63];
   logic       beat_last [0:63];
   int         nbeats;
   int         lat;
   int         early;
   int         hold_err;

   task automatic wait_ready();
      int k = 0;
      while (!client.req_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      if (!client.req_ready) check("req_ready_timeout", 32'd0, 32'd1);
   endtask

   // Read burst; optional stall of the first beat, optional chained request
   // (adr 29, len 0) held valid throughout the burst.
   task automatic read_burst(input logic [4:0] a, input logic [4:0] len,
                             input int stall, input bit chain);
      int         edges;
      bit         done;
      logic [7:0] held;
      nbeats = 0; lat = -1; early = 0; hold_err = 0;
      client.rsp_ready = 1'b1;
      client.req_write = 1'b0;
      client.req_adr   = a;
      client.req_len   = len;
      client.req_wdata = 8'h00;
      client.req_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;                  // accept edge
      if (chain) begin
         client.req_adr = 5'd29;
         client.req_len = 5'd0;
      end else begin
         client.req_valid = 1'b0;
      end
      edges = 0;
      done  = 1'b0;
      while (!done && edges < 300) begin
         @(posedge clk); #1;
         edges++;
         if (client.req_ready) early++;
         if (client.rsp_valid) begin
            if (lat < 0) lat = edges;
            if (stall > 0 && nbeats == 0) begin
               held = client.rsp_data;
               client.rsp_ready = 1'b0;
               repeat (stall) begin
                  @(posedge clk); #1;
                  edges++;
                  if (client.rsp_data !== held || !client.rsp_valid ||
                      mem_read !== 1'b0 || adr !== a) hold_err++;
               end
               client.rsp_ready = 1'b1;
            end
            beat_data[nbeats] = client.rsp_data;
            beat_last[nbeats] = client.rsp_last;
            nbeats++;
            if (client.rsp_last) done = 1'b1;
         end
      end
      if (!done) check("burst_timeout", 32'd0, 32'd1);
      else begin
         @(posedge clk); #1;              // last beat consumed
      end
      $display("read adr=%0d len=%0d beats=%0d first=0x%0h latency=%0d",
               a, len, nbeats, beat_data[0], lat);
   endtask

   task automatic write_single(input logic [4:0] a, input logic [7:0] d);
      int w0;
      client.req_write = 1'b1;
      client.req_adr   = a;
      client.req_wdata = d;
      client.req_len   = 5'd0;
      client.req_valid = 1'b1;
      wait_ready();
      w0 = wr_cnt;
      @(posedge clk); #1;
      client.req_valid = 1'b0;
      check("wr_memwen_high", memwen, 1);
      check("wr_ready_low", client.req_ready, 0);
      check("wr_adr", adr, a);
      check("wr_data", data, d);
      @(posedge clk); #1;
      check("wr_memwen_low", memwen, 0);
      check("wr_ready_back", client.req_ready, 1);
      check("wr_strobe_cycles", wr_cnt - w0, 1);
      $display("write adr=%0d data=0x%0h", a, d);
   endtask

   initial begin
      int         r0;
      logic [31:0] seen;
      client.req_valid = 1'b0;
      client.req_write = 1'b0;
      client.req_adr   = '0;
      client.req_wdata = '0;
      client.req_len   = '0;
      client.rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", client.req_ready, 0);
      check("rst_rsp_valid", client.rsp_valid, 0);
      check("rst_rsp_data", client.rsp_data, 0);
      check("rst_memwen", memwen, 0);
      check("rst_memread", mem_read, 0);
      check("rst_adr", adr, 0);
      check("rst_busy", busy, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_req_ready", client.req_ready, 1);

      // 1: single read
      r0 = rd_cnt;
      read_burst(5'd28, 5'd0, 0, 1'b0);
      check("t1_beats", nbeats, 1);
      check("t1_data", beat_data[0], 8'hAA);
      check("t1_last", beat_last[0], 1);
      check("t1_latency", lat, 2);
      check("t1_memread_cycles", rd_cnt - r0, 1);

      // 2: wrapping burst
      rd_adr_q.delete();
      read_burst(5'd30, 5'd3, 0, 1'b0);
      check("t2_beats", nbeats, 4);
      check("t2_d0", beat_data[0], 8'h10);
      check("t2_d1", beat_data[1], 8'h00);
      check("t2_d2", beat_data[2], 8'h9D);
      check("t2_d3", beat_data[3], 8'h9D);
      check("t2_last_pattern", {beat_last[0], beat_last[1], beat_last[2], beat_last[3]}, 4'b0001);
      check("t2_adr_count", rd_adr_q.size(), 4);
      if (rd_adr_q.size() == 4) begin
         check("t2_adr0", rd_adr_q[0], 30);
         check("t2_adr1", rd_adr_q[1], 31);
         check("t2_adr2", rd_adr_q[2], 0);
         check("t2_adr3", rd_adr_q[3], 1);
      end

      // 3: write then read back
      write_single(5'd5, 8'h3C);
      read_burst(5'd5, 5'd0, 0, 1'b0);
      check("t3_readback", beat_data[0], 8'h3C);

      // 4: backpressure on first beat
      read_burst(5'd27, 5'd1, 5, 1'b0);
      check("t4_beats", nbeats, 2);
      check("t4_hold_err", hold_err, 0);
      check("t4_d0", beat_data[0], 8'h66);
      check("t4_d1", beat_data[1], 8'hAA);
      check("t4_last", {beat_last[0], beat_last[1]}, 2'b01);

      // Full-depth burst covers every location once
      rd_adr_q.delete();
      read_burst(5'd3, 5'd31, 0, 1'b0);
      check("full_beats", nbeats, 32);
      seen = '0;
      foreach (rd_adr_q[i]) seen[rd_adr_q[i]] = 1'b1;
      check("full_reads", rd_adr_q.size(), 32);
      check("full_coverage", seen, 32'hFFFF_FFFF);

      // 5: reset mid-burst
      client.req_write = 1'b0;
      client.req_adr   = 5'd0;
      client.req_len   = 5'd3;
      client.req_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;
      client.req_valid = 1'b0;
      check("t5_memread_pre", mem_read, 1);
      rst_n = 1'b0;
      #1;
      check("t5_memread_rst", mem_read, 0);
      check("t5_rsp_valid_rst", client.rsp_valid, 0);
      check("t5_rsp_last_rst", client.rsp_last, 0);
      check("t5_busy_rst", busy, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("t5_ready_before_edge", client.req_ready, 0);
      @(posedge clk); #1;
      check("t5_ready_after_edge", client.req_ready, 1);
      read_burst(5'd27, 5'd0, 0, 1'b0);
      check("t5_data", beat_data[0], 8'h66);

      // 6: request held during a burst
      read_burst(5'd27, 5'd1, 0, 1'b1);
      check("t6_early_ready", early, 0);
      check("t6_burst_d1", beat_data[1], 8'hAA);
      check("t6_pending_valid", client.req_valid, 1);
      read_burst(5'd29, 5'd0, 0, 1'b0);
      check("t6_second_data", beat_data[0], 8'h08);
      check("t6_second_last", beat_last[0], 1);

      check("strobe_overlap", both_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
